// File: rtl/map_request_server.sv
// Two-port round-robin read server in front of a shared map BROM with a fixed read latency.
// Optional MAP_SERVER_OOB_WALL_EN: out-of-range addresses return OOB_VALUE without touching the BROM.
module map_request_server #(
    parameter int          N            = 24,
    parameter int          READ_LATENCY = 2,
    parameter logic [3:0]  OOB_VALUE    = 4'd1,
    localparam int         AW           = $clog2(N*N)
) (
    input  logic          pixel_clk_in,
    input  logic          rst_n_in,
    input  logic          map_request_a_in,
    input  logic          map_request_b_in,
    input  logic [AW-1:0] map_addra_a_in,
    input  logic [AW-1:0] map_addra_b_in,
    output logic [3:0]    map_data_a_out,
    output logic [3:0]    map_data_b_out,
    output logic          map_data_valid_a_out,
    output logic          map_data_valid_b_out,
    output logic [AW-1:0] bram_addr_out,
    output logic          bram_en_out,
    input  logic [3:0]    bram_data_in,
    output logic          server_busy_out
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INFLIGHT = 2'd1,
        S_HOLDOFF  = 2'd2
    } port_state_t;

    port_state_t   state_a, state_b, next_a, next_b;
    logic          ptr_b, ptr_b_next;
    logic          elig_a, elig_b, grant_a, grant_b, grant_oob;
    logic          resp_a, resp_b;
    logic [AW-1:0] grant_addr;
    logic [3:0]    resp_data;

    // bit 0 marks a read owned by A, bit 1 a read owned by B
    logic [1:0]    tag_pipe [READ_LATENCY+1];
    logic          oob_pipe [READ_LATENCY+1];

`ifdef MAP_SERVER_OOB_WALL_EN
    localparam logic [AW:0] CELLS = (AW+1)'(N*N);
    assign grant_oob = ({1'b0, grant_addr} >= CELLS);
`else
    assign grant_oob = 1'b0;
`endif

    always_comb begin
        elig_a     = (state_a == S_IDLE) && map_request_a_in;
        elig_b     = (state_b == S_IDLE) && map_request_b_in;
        grant_a    = elig_a && !(elig_b && ptr_b);
        grant_b    = elig_b && !(elig_a && !ptr_b);
        ptr_b_next = (elig_a && elig_b) ? !ptr_b : ptr_b;
        grant_addr = grant_b ? map_addra_b_in : map_addra_a_in;
        resp_a     = tag_pipe[READ_LATENCY][0];
        resp_b     = tag_pipe[READ_LATENCY][1];
        resp_data  = oob_pipe[READ_LATENCY] ? OOB_VALUE : bram_data_in;
        server_busy_out = elig_a || elig_b ||
                          (state_a == S_INFLIGHT) || (state_b == S_INFLIGHT);

        next_a = state_a;
        case (state_a)
            S_IDLE:     if (grant_a)           next_a = S_INFLIGHT;
            S_INFLIGHT: if (resp_a)            next_a = S_HOLDOFF;
            S_HOLDOFF:  if (!map_request_a_in) next_a = S_IDLE;
            default:                           next_a = S_IDLE;
        endcase

        next_b = state_b;
        case (state_b)
            S_IDLE:     if (grant_b)           next_b = S_INFLIGHT;
            S_INFLIGHT: if (resp_b)            next_b = S_HOLDOFF;
            S_HOLDOFF:  if (!map_request_b_in) next_b = S_IDLE;
            default:                           next_b = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_a <= S_IDLE;
            state_b <= S_IDLE;
            ptr_b   <= 1'b0;
        end else begin
            state_a <= next_a;
            state_b <= next_b;
            ptr_b   <= ptr_b_next;
        end
    end

    // Clearing the tag pipe on reset drops any BROM data still on its way back.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i <= READ_LATENCY; i++) begin
                tag_pipe[i] <= 2'b00;
                oob_pipe[i] <= 1'b0;
            end
            bram_addr_out        <= '0;
            bram_en_out          <= 1'b0;
            map_data_a_out       <= 4'd0;
            map_data_b_out       <= 4'd0;
            map_data_valid_a_out <= 1'b0;
            map_data_valid_b_out <= 1'b0;
        end else begin
            tag_pipe[0] <= {grant_b, grant_a};
            oob_pipe[0] <= (grant_a || grant_b) && grant_oob;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
                oob_pipe[i] <= oob_pipe[i-1];
            end
            if (grant_a || grant_b)
                bram_addr_out <= grant_addr;
            bram_en_out          <= (grant_a || grant_b) && !grant_oob;
            map_data_valid_a_out <= resp_a;
            map_data_valid_b_out <= resp_b;
            if (resp_a)
                map_data_a_out <= resp_data;
            if (resp_b)
                map_data_b_out <= resp_data;
        end
    end

endmodule

// File: tb/tb_map_request_server.sv
// Randomized bench for map_request_server: a BROM model plus a transaction-level scheduler
// that predicts grants, response cycles and returned values from the arbitration rules.
module tb_map_request_server;

    localparam int N   = 24;
    localparam int L   = 2;
    localparam int AW  = $clog2(N*N);
    localparam logic [3:0] OOB = 4'd1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [3:0]    data_a, data_b, bram_data;
    logic          valid_a, valid_b, bram_en, busy;
    logic [AW-1:0] bram_addr;

    map_request_server #(.N(N), .READ_LATENCY(L), .OOB_VALUE(OOB)) dut (
        .pixel_clk_in         (clk),
        .rst_n_in             (rst_n),
        .map_request_a_in     (req_a),
        .map_request_b_in     (req_b),
        .map_addra_a_in       (addr_a),
        .map_addra_b_in       (addr_b),
        .map_data_a_out       (data_a),
        .map_data_b_out       (data_b),
        .map_data_valid_a_out (valid_a),
        .map_data_valid_b_out (valid_b),
        .bram_addr_out        (bram_addr),
        .bram_en_out          (bram_en),
        .bram_data_in         (bram_data),
        .server_busy_out      (busy)
    );

    always #5 clk = ~clk;

    // BROM: data for the address presented at edge E is on the bus after edge E+L
    logic [3:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] ap  [L];
    always @(posedge clk) begin
        ap[0] <= bram_addr;
        for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
    end
    assign bram_data = mem[ap[L-1]];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference scheduler: 0 = free, 1 = waiting for data, 2 = served, waiting for request drop
    int            m_st  [2] = '{0, 0};
    int            m_due [2] = '{0, 0};
    logic [3:0]    m_val [2] = '{4'd0, 4'd0};
    logic [3:0]    e_data[2] = '{4'd0, 4'd0};
    logic          e_vld [2] = '{1'b0, 1'b0};
    logic          m_turn_b = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic          e_en = 1'b0;
    int            mcyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = '{0, 0}; e_data = '{4'd0, 4'd0}; e_vld = '{1'b0, 1'b0};
            m_turn_b = 1'b0; e_addr = '0; e_en = 1'b0;
        end else begin
            logic          rq [2];
            logic          want [2];
            logic [AW-1:0] ad;
            int            win;
            mcyc++;
            rq[0] = req_a; rq[1] = req_b;
            for (int p = 0; p < 2; p++) want[p] = (m_st[p] == 0) && rq[p];
            win = -1;
            if (want[0] && want[1]) begin
                win = m_turn_b ? 1 : 0;
                m_turn_b = !m_turn_b;
            end else if (want[0]) win = 0;
            else if (want[1]) win = 1;
            e_vld = '{1'b0, 1'b0};
            e_en  = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (m_st[p] == 1 && m_due[p] == mcyc) begin
                    e_vld[p]  = 1'b1;
                    e_data[p] = m_val[p];
                    m_st[p]   = 2;
                end else if (m_st[p] == 2 && !rq[p]) begin
                    m_st[p] = 0;
                end
            end
            if (win >= 0) begin
                ad = (win == 1) ? addr_b : addr_a;
                m_st[win]  = 1;
                m_due[win] = mcyc + L + 1;
                e_addr     = ad;
`ifdef MAP_SERVER_OOB_WALL_EN
                e_en         = (int'(ad) < N*N);
                m_val[win]   = (int'(ad) < N*N) ? mem[ad] : OOB;
`else
                e_en         = 1'b1;
                m_val[win]   = mem[ad];
`endif
            end
        end
    end

    always @(negedge clk) begin
        check_val("valid_a", valid_a, e_vld[0]);
        check_val("valid_b", valid_b, e_vld[1]);
        check_val("data_a", data_a, e_data[0]);
        check_val("data_b", data_b, e_data[1]);
        check_val("bram_addr", bram_addr, e_addr);
        check_val("bram_en", bram_en, e_en);
        check_val("busy", busy, (m_st[0] == 1) || (m_st[0] == 0 && req_a) ||
                                (m_st[1] == 1) || (m_st[1] == 0 && req_b));
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Raise a request, wait (bounded) for its valid pulse, hold for hold_extra edges, then drop.
    task automatic serve(input int p, input logic [AW-1:0] ad, input int hold_extra,
                         output int lat, output logic [3:0] got);
        int t0, n;
        logic seen;
        if (p == 0) begin addr_a = ad; req_a = 1'b1; end
        else        begin addr_b = ad; req_b = 1'b1; end
        t0 = cyc; n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            step(1); n++;
            seen = (p == 0) ? valid_a : valid_b;
        end
        check_val(p == 0 ? "served_a" : "served_b", seen, 1'b1);
        lat = cyc - t0 - 1;
        got = (p == 0) ? data_a : data_b;
        step(hold_extra);
        if (p == 0) req_a = 1'b0; else req_b = 1'b0;
    endtask

    initial begin
        int la, lb, vcount;
        logic [3:0] ga, gb;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < L; i++) ap[i] = '0;
        mem[25] = 4'd3;
        step(3);
        rst_n = 1'b1;
        step(2);

        // single uncontended request
        serve(0, 25, 0, la, ga);
        check_val("lat_single", la, L + 1);
        check_val("data_single", ga, 4'd3);
        step(2);

        // tie: A first, then B one edge later; next tie goes to B
        fork
            serve(0, 5, 0, la, ga);
            serve(1, 7, 0, lb, gb);
        join
        check_val("tie1_lat_a", la, L + 1);
        check_val("tie1_lat_b", lb, L + 2);
        check_val("tie1_data_b", gb, mem[7]);
        step(2);
        fork
            serve(0, 9, 0, la, ga);
            serve(1, 11, 0, lb, gb);
        join
        check_val("tie2_lat_b", lb, L + 1);
        check_val("tie2_lat_a", la, L + 2);
        step(2);

        // request held through and past its valid cycle, then a fresh request
        serve(0, 40, 1, la, ga);
        check_val("hold_data", ga, mem[40]);
        step(1);
        serve(0, 41, 0, la, ga);
        check_val("rereq_lat", la, L + 1);
        check_val("rereq_data", ga, mem[41]);
        step(2);

        // reset one edge after a grant: the read must vanish
        addr_a = 10'd100; req_a = 1'b1;
        step(1);
        check_val("rst_grant_en", bram_en, 1'b1);
        step(1);
        rst_n = 1'b0; req_a = 1'b0;
        vcount = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            vcount += int'(valid_a) + int'(valid_b);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            vcount += int'(valid_a) + int'(valid_b);
        end
        check_val("rst_no_valid", vcount, 0);

        // address beyond the map
        serve(0, 600, 0, la, ga);
        check_val("oob_lat", la, L + 1);
`ifdef MAP_SERVER_OOB_WALL_EN
        check_val("oob_data", ga, OOB);
`else
        check_val("oob_data", ga, mem[600]);
`endif
        step(2);

        // back-to-back random traffic on both ports
        for (int i = 0; i < (1 << AW); i++) mem[i] = 4'($urandom_range(0, 15));
        fork
            begin
                int l; logic [3:0] g; logic [AW-1:0] ad;
                for (int k = 0; k < 20; k++) begin
                    ad = AW'($urandom_range(0, N*N - 1));
                    serve(0, ad, $urandom_range(0, 2), l, g);
                    check_val("rand_a", g, mem[ad]);
                    step($urandom_range(1, 3));
                end
            end
            begin
                int l; logic [3:0] g; logic [AW-1:0] ad;
                for (int k = 0; k < 20; k++) begin
                    ad = AW'($urandom_range(0, N*N - 1));
                    serve(1, ad, $urandom_range(0, 2), l, g);
                    check_val("rand_b", g, mem[ad]);
                    step($urandom_range(1, 3));
                end
            end
        join
        step(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
